c7bbiu_rd_arb_n: RTL and testbench

- Parametrised N-master AXI read arbiter and response router for the c7b bus interface unit; successor to the fixed two-master IFU/LSU read arbiter.
- Grants requesters round-robin and registers the winner into one AR slot.
- Tracks outstanding reads per master, routes R beats back by AXI ID, and supports per-master cancel that silently drops in-flight returns.

---
 rtl/c7bbiu_rd_arb_n.sv | 183 ++++++++++++++++++
 tb/tb_c7bbiu_rd_arb_n.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c7bbiu_rd_arb_n.sv
// N-master AXI read arbiter: round-robin AR issue through one slot, R routing by ID, per-master cancel.
// Define C7BBIU_RD_BURST_EN to take per-master burst lengths and report a sticky error on the last beat.
module c7bbiu_rd_arb_n #(
    parameter int NUM_MST  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int ID_W     = 4,
    parameter int MAX_OUTS = 2
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_MST-1:0]        mst_rd_req,
    input  logic [NUM_MST*ADDR_W-1:0] mst_rd_addr,
`ifdef C7BBIU_RD_BURST_EN
    input  logic [NUM_MST*8-1:0]      mst_rd_len,
`endif
    input  logic [NUM_MST-1:0]        mst_rd_cancel,
    output logic [NUM_MST-1:0]        biu_mst_rd_ack,
    output logic [NUM_MST-1:0]        biu_mst_data_valid,
    output logic [DATA_W-1:0]         biu_mst_data,
    output logic [NUM_MST-1:0]        biu_mst_err,
    input  logic                      ext_biu_ar_ready,
    output logic                      biu_ext_ar_valid,
    output logic [ID_W-1:0]           biu_ext_ar_id,
    output logic [ADDR_W-1:0]         biu_ext_ar_addr,
    output logic [7:0]                biu_ext_ar_len,
    output logic [2:0]                biu_ext_ar_size,
    output logic [1:0]                biu_ext_ar_burst,
    output logic                      biu_ext_ar_lock,
    output logic [3:0]                biu_ext_ar_cache,
    output logic [2:0]                biu_ext_ar_prot,
    output logic                      biu_ext_r_ready,
    input  logic                      ext_biu_r_valid,
    input  logic [ID_W-1:0]           ext_biu_r_id,
    input  logic [DATA_W-1:0]         ext_biu_r_data,
    input  logic                      ext_biu_r_last,
    input  logic [1:0]                ext_biu_r_resp
);

    localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CNT_W = 3;
    localparam logic [ID_W:0]  NUM_MST_ID  = (ID_W+1)'(NUM_MST);
    localparam logic [IDX_W:0] NUM_MST_IDX = (IDX_W+1)'(NUM_MST);

    logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic              ar_valid_reg, ar_valid_next;
    logic [ID_W-1:0]   ar_id_reg, ar_id_next;
    logic [ADDR_W-1:0] ar_addr_reg, ar_addr_next;
    logic [7:0]        ar_len_reg, ar_len_next;

    logic [NUM_MST-1:0] eligible;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [IDX_W:0]     cand;
    logic               grant_vld;
    logic               r_id_ok;

    // Search starts one past the last winner and wraps, so the previous winner has lowest priority.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_MST; k++) begin
            cand = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (cand >= NUM_MST_IDX)
                cand = cand - NUM_MST_IDX;
            if (!win_found && eligible[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign grant_vld = resetn & win_found & (~ar_valid_reg | ext_biu_ar_ready);
    assign r_id_ok   = ({1'b0, ext_biu_r_id} < NUM_MST_ID);

    always_comb begin
        rr_ptr_next   = rr_ptr_reg;
        ar_valid_next = ar_valid_reg;
        ar_id_next    = ar_id_reg;
        ar_addr_next  = ar_addr_reg;
        ar_len_next   = ar_len_reg;
        if (ar_valid_reg && ext_biu_ar_ready)
            ar_valid_next = 1'b0;
        if (grant_vld) begin
            rr_ptr_next   = win_idx;
            ar_valid_next = 1'b1;
            ar_id_next    = ID_W'(win_idx);
            ar_addr_next  = mst_rd_addr[win_idx*ADDR_W +: ADDR_W];
`ifdef C7BBIU_RD_BURST_EN
            ar_len_next   = mst_rd_len[win_idx*8 +: 8];
`else
            ar_len_next   = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_reg   <= IDX_W'(NUM_MST - 1);
            ar_valid_reg <= 1'b0;
            ar_id_reg    <= '0;
            ar_addr_reg  <= '0;
            ar_len_reg   <= '0;
        end else begin
            rr_ptr_reg   <= rr_ptr_next;
            ar_valid_reg <= ar_valid_next;
            ar_id_reg    <= ar_id_next;
            ar_addr_reg  <= ar_addr_next;
            ar_len_reg   <= ar_len_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MST; gi++) begin : g_mst
            logic [CNT_W-1:0] outs_cnt_reg, outs_cnt_next;
            logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
            logic             r_hit, r_done, dropping;

            assign r_hit    = ext_biu_r_valid & r_id_ok & (ext_biu_r_id == ID_W'(gi));
            assign r_done   = r_hit & ext_biu_r_last;
            assign dropping = (drop_cnt_reg != '0);

            assign eligible[gi]       = mst_rd_req[gi] & ~mst_rd_cancel[gi] &
                                        (outs_cnt_reg < CNT_W'(MAX_OUTS));
            assign biu_mst_rd_ack[gi] = grant_vld & (win_idx == IDX_W'(gi));
            assign biu_mst_data_valid[gi] = resetn & r_hit & ~dropping;

            // Cancel snapshots the post-update count so a return completing this cycle is not double-dropped.
            always_comb begin
                outs_cnt_next = outs_cnt_reg;
                drop_cnt_next = drop_cnt_reg;
                if (biu_mst_rd_ack[gi] && !r_done && outs_cnt_reg != CNT_W'(MAX_OUTS))
                    outs_cnt_next = outs_cnt_reg + 1'b1;
                else if (!biu_mst_rd_ack[gi] && r_done && outs_cnt_reg != '0)
                    outs_cnt_next = outs_cnt_reg - 1'b1;
                if (mst_rd_cancel[gi])
                    drop_cnt_next = outs_cnt_next;
                else if (r_done && dropping)
                    drop_cnt_next = drop_cnt_reg - 1'b1;
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    outs_cnt_reg <= '0;
                    drop_cnt_reg <= '0;
                end else begin
                    outs_cnt_reg <= outs_cnt_next;
                    drop_cnt_reg <= drop_cnt_next;
                end
            end

`ifdef C7BBIU_RD_BURST_EN
            logic err_sticky_reg, err_now;
            assign err_now         = err_sticky_reg | (ext_biu_r_resp != 2'b00);
            assign biu_mst_err[gi] = biu_mst_data_valid[gi] & ext_biu_r_last & err_now;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn)
                    err_sticky_reg <= 1'b0;
                else if (r_hit)
                    err_sticky_reg <= ext_biu_r_last ? 1'b0 : err_now;
            end
`else
            assign biu_mst_err[gi] = biu_mst_data_valid[gi] & (ext_biu_r_resp != 2'b00);
`endif
        end
    endgenerate

    assign biu_mst_data     = ext_biu_r_data;
    assign biu_ext_ar_valid = ar_valid_reg;
    assign biu_ext_ar_id    = ar_id_reg;
    assign biu_ext_ar_addr  = ar_addr_reg;
    assign biu_ext_ar_len   = ar_len_reg;
    assign biu_ext_ar_size  = 3'b010;
    assign biu_ext_ar_burst = 2'b01;
    assign biu_ext_ar_lock  = 1'b0;
    assign biu_ext_ar_cache = 4'b0000;
    assign biu_ext_ar_prot  = 3'b000;
    assign biu_ext_r_ready  = 1'b1;

endmodule

// File: tb/tb_c7bbiu_rd_arb_n.sv
// Bench for c7bbiu_rd_arb_n (NUM_MST=3, MAX_OUTS=2): directed scenarios with literal expectations,
// then random traffic against a queue-based reference model of grants, outstanding reads and drops.
module tb_c7bbiu_rd_arb_n;
    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic resetn;
    logic [NM-1:0]    req, cancel;
    logic [NM*AW-1:0] addr;
    logic             ar_ready, r_valid, r_last;
    logic [IW-1:0]    r_id;
    logic [DW-1:0]    r_data;
    logic [1:0]       r_resp;

    logic [NM-1:0] ack, dv, err;
    logic [DW-1:0] data;
    logic          ar_valid, ar_lock, r_ready;
    logic [IW-1:0] ar_id;
    logic [AW-1:0] ar_addr;
    logic [7:0]    ar_len;
    logic [2:0]    ar_size, ar_prot;
    logic [1:0]    ar_burst;
    logic [3:0]    ar_cache;

    c7bbiu_rd_arb_n #(.NUM_MST(NM), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW), .MAX_OUTS(MO)) dut (
        .clk(clk), .resetn(resetn),
        .mst_rd_req(req), .mst_rd_addr(addr), .mst_rd_cancel(cancel),
        .biu_mst_rd_ack(ack), .biu_mst_data_valid(dv), .biu_mst_data(data), .biu_mst_err(err),
        .ext_biu_ar_ready(ar_ready), .biu_ext_ar_valid(ar_valid), .biu_ext_ar_id(ar_id),
        .biu_ext_ar_addr(ar_addr), .biu_ext_ar_len(ar_len), .biu_ext_ar_size(ar_size),
        .biu_ext_ar_burst(ar_burst), .biu_ext_ar_lock(ar_lock), .biu_ext_ar_cache(ar_cache),
        .biu_ext_ar_prot(ar_prot), .biu_ext_r_ready(r_ready),
        .ext_biu_r_valid(r_valid), .ext_biu_r_id(r_id), .ext_biu_r_data(r_data),
        .ext_biu_r_last(r_last), .ext_biu_r_resp(r_resp)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each master owns a FIFO of granted reads, each entry flagged "dropped".
    int          m_rr;
    bit          m_sv;
    int          m_sid;
    logic [AW-1:0] m_saddr;
    bit          m_q [NM][$];
    int          s_pend [NM];
    int          s_left [NM];
    logic [NM-1:0] last_ack;
    logic [NM-1:0] e_ack, e_dv, e_err;
    int          e_win;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_rr = NM - 1; m_sv = 0; m_sid = 0; m_saddr = '0; last_ack = '0;
        for (int i = 0; i < NM; i++) begin
            m_q[i].delete(); s_pend[i] = 0; s_left[i] = 0;
        end
    endtask

    task automatic m_eval();
        int id;
        bit dropped;
        e_ack = '0; e_dv = '0; e_err = '0; e_win = -1;
        for (int k = 1; k <= NM; k++) begin
            int j;
            j = (m_rr + k) % NM;
            if (e_win < 0 && req[j] && !cancel[j] && m_q[j].size() < MO) e_win = j;
        end
        if (e_win >= 0 && (!m_sv || ar_ready)) e_ack[e_win] = 1'b1;
        if (r_valid && int'(r_id) < NM) begin
            id = int'(r_id);
            dropped = (m_q[id].size() > 0) ? m_q[id][0] : 1'b0;
            if (!dropped) begin
                e_dv[id]  = 1'b1;
                e_err[id] = (r_resp != 2'b00);
            end
        end
    endtask

    task automatic eval_cycle();
        #1;
        m_eval();
        chk("ack", ack, e_ack);
        chk("ar_valid", ar_valid, m_sv);
        if (m_sv) begin
            chk("ar_id", ar_id, m_sid);
            chk("ar_addr", ar_addr, m_saddr);
            chk("ar_len", ar_len, 0);
        end
        chk("data_valid", dv, e_dv);
        chk("err", err, e_err);
        if (e_dv != '0) chk("data", data, r_data);
        chk("r_ready", r_ready, 1);
    endtask

    task automatic end_cycle();
        if (r_valid && int'(r_id) < NM) begin
            int id;
            id = int'(r_id);
            if (s_left[id] > 0) s_left[id]--;
            if (r_last) begin
                if (s_pend[id] > 0) s_pend[id]--;
                s_left[id] = 0;
                if (m_q[id].size() > 0) void'(m_q[id].pop_front());
            end
        end
        if (m_sv && ar_ready) s_pend[m_sid]++;
        last_ack = e_ack;
        if (e_ack != '0) begin
            m_q[e_win].push_back(1'b0);
            m_rr = e_win;
        end
        for (int i = 0; i < NM; i++)
            if (cancel[i])
                for (int j = 0; j < m_q[i].size(); j++) m_q[i][j] = 1'b1;
        if (e_ack != '0) begin
            m_sv = 1; m_sid = e_win; m_saddr = addr[e_win*AW +: AW];
        end else if (m_sv && ar_ready) begin
            m_sv = 0;
        end
        @(posedge clk);
        #1;
        r_valid = 0; r_last = 0; r_resp = 0; cancel = '0;
    endtask

    task automatic rand_inputs(input bit quiet);
        int start;
        if (quiet) begin
            req = '0; cancel = '0; ar_ready = 1;
        end else begin
            for (int i = 0; i < NM; i++) begin
                if (last_ack[i]) begin
                    req[i] = 1'($urandom % 2); addr[i*AW +: AW] = $urandom;
                end else if (!req[i] && $urandom % 3 == 0) begin
                    req[i] = 1; addr[i*AW +: AW] = $urandom;
                end
                cancel[i] = ($urandom % 40 == 0);
            end
            ar_ready = ($urandom % 4 != 0);
        end
        r_valid = 0;
        if (!quiet && $urandom % 25 == 0) begin
            r_valid = 1; r_id = IW'(NM + $urandom % (16 - NM)); r_last = 1'($urandom % 2);
            r_data = $urandom; r_resp = 2'($urandom % 4);
        end else if (quiet || $urandom % 3 != 0) begin
            start = $urandom % NM;
            for (int k = 0; k < NM; k++) begin
                int j;
                j = (start + k) % NM;
                if (!r_valid && s_pend[j] > 0) begin
                    if (s_left[j] == 0) s_left[j] = 1 + $urandom % 2;
                    r_valid = 1; r_id = IW'(j); r_last = (s_left[j] == 1);
                    r_data = $urandom;
                    r_resp = ($urandom % 4 == 0) ? 2'($urandom % 4) : 2'b00;
                end
            end
        end
    endtask

    function automatic bit drained();
        bit d;
        d = !m_sv;
        for (int i = 0; i < NM; i++) if (s_pend[i] != 0 || m_q[i].size() != 0) d = 0;
        return d;
    endfunction

    task automatic drain();
        for (int c = 0; c < 400 && !drained(); c++) begin
            rand_inputs(1); eval_cycle(); end_cycle();
        end
        if (!drained()) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got pending expected none at %0t", $time);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0; req = '1; cancel = '0; addr = '0; ar_ready = 0;
        r_valid = 0; r_id = '0; r_data = '0; r_last = 0; r_resp = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_ar_id", ar_id, 0);
        chk("rst_ar_addr", ar_addr, 0);
        chk("rst_ar_len", ar_len, 0);
        chk("rst_dv", dv, 0);
        chk("rst_err", err, 0);
        chk("ar_size", ar_size, 3'b010);
        chk("ar_burst", ar_burst, 2'b01);
        chk("ar_lock_cache_prot", {ar_lock, ar_cache, ar_prot}, 0);
        resetn = 1; req = '0;

        // Round-robin from the reset pointer, everybody requesting.
        req = 3'b111; ar_ready = 1;
        for (int i = 0; i < NM; i++) addr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 16);
        for (int k = 0; k < 6; k++) begin
            eval_cycle();
            chk("rr_ack_seq", ack, 3'b001 << (k % 3));
            if (k > 0) chk("rr_id_seq", ar_id, (k - 1) % 3);
            end_cycle();
        end
        eval_cycle();
        chk("max_outs_block", ack, 0);
        chk("rr_last_id", ar_id, 2);
        end_cycle();
        req = 3'b001;
        eval_cycle(); chk("max_outs_block2", ack, 0); end_cycle();
        r_valid = 1; r_id = 0; r_last = 1; r_data = 32'h1111_2222;
        eval_cycle(); chk("ret_m0_dv", dv, 3'b001); chk("ret_same_cycle_ack", ack, 0); end_cycle();
        eval_cycle(); chk("ack_after_ret", ack, 3'b001); end_cycle();
        req = '0; cancel = 3'b001;
        eval_cycle(); end_cycle();
        for (int k = 0; k < 2; k++) begin
            r_valid = 1; r_id = 0; r_last = 1; r_data = 32'h5555_0000 + 32'(k);
            eval_cycle(); chk("cancel_drop_dv", dv, 0); end_cycle();
        end
        req = 3'b001; addr[0 +: AW] = 32'hC0DE_0000;
        eval_cycle(); chk("post_cancel_ack", ack, 3'b001); end_cycle();
        req = '0;
        eval_cycle(); end_cycle();
        r_valid = 1; r_id = 0; r_last = 1; r_data = 32'hDEAD_BEEF;
        eval_cycle(); chk("new_read_dv", dv, 3'b001); chk("new_read_data", data, 32'hDEAD_BEEF); end_cycle();
        drain();

        // AR stall on master 1.
        req = 3'b010; addr[AW +: AW] = 32'hA000_1234; ar_ready = 0;
        eval_cycle(); chk("stall_ack", ack, 3'b010); end_cycle();
        for (int k = 0; k < 4; k++) begin
            eval_cycle();
            chk("stall_valid", ar_valid, 1);
            chk("stall_id", ar_id, 1);
            chk("stall_addr", ar_addr, 32'hA000_1234);
            chk("stall_no_ack", ack, 0);
            end_cycle();
        end
        ar_ready = 1;
        eval_cycle(); chk("b2b_ack", ack, 3'b010); chk("b2b_valid", ar_valid, 1); end_cycle();
        req = '0;
        eval_cycle(); chk("b2b_second", ar_valid, 1); end_cycle();
        r_valid = 1; r_id = 1; r_last = 1; r_resp = 2'b00; r_data = 32'h0BAD_F00D;
        eval_cycle(); chk("m1_dv", dv, 3'b010); chk("m1_err_ok", err, 0); end_cycle();
        r_valid = 1; r_id = 1; r_last = 1; r_resp = 2'b10; r_data = 32'h0EE0_0EE0;
        eval_cycle(); chk("m1_err_dv", dv, 3'b010); chk("m1_err", err, 3'b010); end_cycle();
        r_valid = 1; r_id = 5; r_last = 1; r_resp = 2'b10;
        eval_cycle(); chk("stray_dv", dv, 0); chk("stray_err", err, 0); end_cycle();
        req = 3'b010;
        eval_cycle(); chk("stray_untouched_ack", ack, 3'b010); end_cycle();
        req = '0;

        repeat (3000) begin
            rand_inputs(0); eval_cycle(); end_cycle();
        end
        drain();

        // Asynchronous reset with an AR pending.
        req = 3'b010; addr[AW +: AW] = 32'h7777_0000; ar_ready = 0;
        eval_cycle(); chk("pre_rst_ack", ack, 3'b010); end_cycle();
        eval_cycle(); chk("pre_rst_valid", ar_valid, 1);
        #3;
        resetn = 0;
        #1;
        chk("async_rst_valid", ar_valid, 0);
        chk("async_rst_ack", ack, 0);
        chk("async_rst_id", ar_id, 0);
        chk("async_rst_addr", ar_addr, 0);
        req = '0;
        m_reset();
        @(posedge clk); @(posedge clk); #1;
        resetn = 1;
        req = 3'b111; ar_ready = 1;
        for (int k = 0; k < 3; k++) begin
            eval_cycle(); chk("post_rst_rr", ack, 3'b001 << k); end_cycle();
        end
        req = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
